jt51_wrqueue: RTL and testbench

// - Host-side write buffer directly upstream of the JT51 register interface; its write/a0/din outputs drive the register block.
// - Host pushes {register, value} pairs at full clk rate.
// - Block replays each pair as an address write (a0=0) then a data write (a0=1).
// - After each data write it waits for the register block's busy to drop, so the host never has to poll busy.

---
 rtl/jt51_wrqueue.sv | 249 ++++++++++++++++++++++++
 tb/tb_jt51_wrqueue.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt51_wrqueue.sv
// -----------------------------------------------------------------------------
// jt51_wrqueue
// Host-side write buffer that sits directly in front of the JT51 register
// interface. The host pushes {register, value} pairs at full clk rate. Each
// pair is replayed as an address write (a0=0), then GAP idle cycles, then a
// data write (a0=1). After the data write the engine waits for the register
// block's busy flag to drop before it retires the entry. The host never has
// to poll busy.
//
// Optional feature, selected at compile time:
//   JT51_WRQ_ADDR_CACHE_EN
//     The engine remembers the last register address it wrote. When the next
//     entry targets the same register, the address strobe and the gap are
//     skipped and only the data strobe is issued.
//
// Parameters
//   AW   log2 of the FIFO depth (entries are 16 bits wide)
//   GAP  idle cycles with write=0 between the address and data strobes (1..3)
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   host_wr       push strobe, one entry per cycle while high
//   host_addr     register number of the pushed entry
//   host_data     value of the pushed entry
//   host_full     FIFO holds 2**AW entries
//   host_empty    FIFO empty and engine idle
//   host_level    stored entries; the entry being replayed still counts
//   ovf           sticky flag, set when a push is dropped
//   ovf_clr       clears ovf (a simultaneous drop wins)
//   write         single-cycle write strobe to the register block
//   a0            0 = address phase, 1 = data phase
//   din           address or data byte for the register block
//   busy          busy flag returned by the register block
//   dbg_state     current engine state (state_t encoding)
//
// Handshake: host_wr has no back-pressure. A push is accepted when the FIFO
// has room, or when it is full and the head is retired in the same cycle;
// otherwise it is dropped and ovf records the loss.
// -----------------------------------------------------------------------------
module jt51_wrqueue #(
  parameter int AW  = 3,
  parameter int GAP = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          host_wr,
  input  logic [7:0]    host_addr,
  input  logic [7:0]    host_data,
  output logic          host_full,
  output logic          host_empty,
  output logic [AW:0]   host_level,
  output logic          ovf,
  input  logic          ovf_clr,
  output logic          write,
  output logic          a0,
  output logic [7:0]    din,
  input  logic          busy,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_GAP    = 3'd2,
    S_DATA   = 3'd3,
    S_SETTLE = 3'd4,
    S_WAIT   = 3'd5
  } state_t;

  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] DEPTH_L  = (AW+1)'(DEPTH);
  localparam logic [1:0]  GAP_LAST = 2'(GAP - 1);

  // ---------------------------------------------------------------------------
  // FIFO storage
  // ---------------------------------------------------------------------------
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic [AW:0]   level_nxt;
  logic          push_ok;
  logic          pop;
  logic [7:0]    head_addr;
  logic [7:0]    head_data;

  assign head_addr = mem[rd_ptr][15:8];
  assign head_data = mem[rd_ptr][7:0];

  // When full, the head slot is free to be overwritten on the very edge that
  // retires it, since wr_ptr == rd_ptr and rd_ptr moves on at that edge.
  assign push_ok = host_wr && ((level != DEPTH_L) || pop);

  always_comb begin
    level_nxt = level;
    case ({push_ok, pop})
      2'b10:   level_nxt = level + (AW+1)'(1);
      2'b01:   level_nxt = level - (AW+1)'(1);
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {host_addr, host_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt;
      // A dropped push takes priority over a clear in the same cycle.
      if (host_wr && !push_ok) ovf <= 1'b1;
      else if (ovf_clr)        ovf <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Replay engine
  // write/a0/din are registered alongside the state, so write is high exactly
  // while the engine sits in ADDR or DATA and a0/din hold between strobes.
  // ---------------------------------------------------------------------------
  state_t     state;
  state_t     state_nxt;
  logic [1:0] gap_cnt;
  logic [1:0] gap_cnt_nxt;
  logic       write_nxt;
  logic       a0_nxt;
  logic [7:0] din_nxt;

`ifdef JT51_WRQ_ADDR_CACHE_EN
  logic [7:0] last_addr;
  logic       last_valid;
  logic       cache_hit;
  logic       cache_load;

  assign cache_hit = last_valid && (head_addr == last_addr);
`endif

  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    write_nxt   = 1'b0;
    a0_nxt      = a0;
    din_nxt     = din;
    pop         = 1'b0;
`ifdef JT51_WRQ_ADDR_CACHE_EN
    cache_load  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (level != '0) begin
`ifdef JT51_WRQ_ADDR_CACHE_EN
          if (cache_hit) begin
            state_nxt = S_DATA;
            write_nxt = 1'b1;
            a0_nxt    = 1'b1;
            din_nxt   = head_data;
          end else begin
            state_nxt  = S_ADDR;
            write_nxt  = 1'b1;
            a0_nxt     = 1'b0;
            din_nxt    = head_addr;
            cache_load = 1'b1;
          end
`else
          state_nxt = S_ADDR;
          write_nxt = 1'b1;
          a0_nxt    = 1'b0;
          din_nxt   = head_addr;
`endif
        end
      end
      S_ADDR: begin
        state_nxt   = S_GAP;
        gap_cnt_nxt = 2'd0;
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = S_DATA;
          write_nxt = 1'b1;
          a0_nxt    = 1'b1;
          din_nxt   = head_data;
        end else begin
          gap_cnt_nxt = gap_cnt + 2'd1;
        end
      end
      S_DATA: begin
        state_nxt = S_SETTLE;
      end
      // busy rises on the edge that samples the data strobe, so it is only
      // trustworthy from the following cycle on.
      S_SETTLE: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!busy) begin
          pop       = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      gap_cnt <= 2'd0;
      write   <= 1'b0;
      a0      <= 1'b0;
      din     <= 8'd0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_cnt_nxt;
      write   <= write_nxt;
      a0      <= a0_nxt;
      din     <= din_nxt;
    end
  end

`ifdef JT51_WRQ_ADDR_CACHE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_addr  <= 8'd0;
      last_valid <= 1'b0;
    end else if (cache_load) begin
      last_addr  <= head_addr;
      last_valid <= 1'b1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Status
  // ---------------------------------------------------------------------------
  assign host_level = level;
  assign host_full  = (level == DEPTH_L);
  assign host_empty = (level == '0) && (state == S_IDLE);
  assign dbg_state  = state;

endmodule

// File: tb/tb_jt51_wrqueue.sv
// -----------------------------------------------------------------------------
// Testbench for jt51_wrqueue (AW=3, GAP=1).
// A small register-block model raises busy for BUSY_LEN cycles after each
// data strobe it samples; busy_hold forces busy high. Every strobe sampled on
// a rising edge is logged as {a0, din} and compared with the expected queue.
// -----------------------------------------------------------------------------
module tb_jt51_wrqueue;

  localparam int AW       = 3;
  localparam int GAP      = 1;
  localparam int BUSY_LEN = 5;
  localparam logic [2:0] ST_WAIT = 3'd5;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst;
  logic          host_wr;
  logic [7:0]    host_addr;
  logic [7:0]    host_data;
  logic          host_full;
  logic          host_empty;
  logic [AW:0]   host_level;
  logic          ovf;
  logic          ovf_clr;
  logic          write;
  logic          a0;
  logic [7:0]    din;
  logic          busy;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  jt51_wrqueue #(.AW(AW), .GAP(GAP)) dut (
    .clk        (clk),
    .rst        (rst),
    .host_wr    (host_wr),
    .host_addr  (host_addr),
    .host_data  (host_data),
    .host_full  (host_full),
    .host_empty (host_empty),
    .host_level (host_level),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr),
    .write      (write),
    .a0         (a0),
    .din        (din),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Register-block model and strobe monitor
  // ---------------------------------------------------------------------------
  logic busy_hold = 1'b0;
  int   busy_cnt  = 0;
  logic prev_write = 1'b0;
  int   pulse_viol = 0;

  assign busy = busy_hold | (busy_cnt != 0);

  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];

  always @(posedge clk) begin
    if (write && a0)       busy_cnt <= BUSY_LEN;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    if (write && prev_write) pulse_viol <= pulse_viol + 1;
    prev_write <= write;
    if (write) got_q.push_back({a0, din});
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic tick();
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    tick();
    n_cmp++;
    if ({write, a0, din} !== 10'd0) begin
      n_err++; $display("FAIL reset_outputs: got write=%b a0=%b din=%h expected 0/0/00", write, a0, din);
    end
    n_cmp++;
    if ({ovf, host_level} !== '0) begin
      n_err++; $display("FAIL reset_ovf_level: got ovf=%b level=%0d expected 0/0", ovf, host_level);
    end
    n_cmp++;
    if ({host_empty, host_full} !== 2'b10) begin
      n_err++; $display("FAIL reset_flags: got empty=%b full=%b expected 1/0", host_empty, host_full);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({write, host_empty, dbg_state} !== {1'b0, 1'b1, 3'd0}) begin
      n_err++; $display("FAIL after_release: got write=%b empty=%b state=%0d expected 0/1/0", write, host_empty, dbg_state);
    end
  endtask

  task automatic test_single();
    int n;
    host_wr = 1'b1; host_addr = 8'h20; host_data = 8'hC7;
    exp_q.push_back({1'b0, 8'h20});
    exp_q.push_back({1'b1, 8'hC7});
    tick();
    host_wr = 1'b0;
    n_cmp++;
    if ({write, host_level, host_empty} !== {1'b0, 4'd1, 1'b0}) begin
      n_err++; $display("FAIL single_pushed: got write=%b level=%0d empty=%b expected 0/1/0", write, host_level, host_empty);
    end
    tick();
    n_cmp++;
    if ({write, a0, din} !== {1'b1, 1'b0, 8'h20}) begin
      n_err++; $display("FAIL single_addr: got write=%b a0=%b din=%h expected 1/0/20", write, a0, din);
    end
    tick();
    n_cmp++;
    if ({write, a0, din} !== {1'b0, 1'b0, 8'h20}) begin
      n_err++; $display("FAIL single_gap: got write=%b a0=%b din=%h expected 0/0/20", write, a0, din);
    end
    tick();
    n_cmp++;
    if ({write, a0, din} !== {1'b1, 1'b1, 8'hC7}) begin
      n_err++; $display("FAIL single_data: got write=%b a0=%b din=%h expected 1/1/c7", write, a0, din);
    end
    tick(); tick();
    n_cmp++;
    if ({write, dbg_state, host_level, busy} !== {1'b0, ST_WAIT, 4'd1, 1'b1}) begin
      n_err++; $display("FAIL single_wait: got write=%b state=%0d level=%0d busy=%b expected 0/5/1/1", write, dbg_state, host_level, busy);
    end
    n = 0;
    while (!host_empty && n < 60) begin tick(); n++; end
    n_cmp++;
    if (n >= 60) begin
      n_err++; $display("FAIL single_drain_timeout: got empty=%b expected 1", host_empty);
    end
    repeat (4) tick();
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL single_strobe_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL single_strobe[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_overflow();
    busy_hold = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      n_cmp++;
      if (host_level !== 4'(i)) begin
        n_err++; $display("FAIL ovf_level[%0d]: got %0d expected %0d", i, host_level, i);
      end
      if (i == 8) begin
        n_cmp++;
        if ({host_full, ovf} !== 2'b10) begin
          n_err++; $display("FAIL ovf_full_after8: got full=%b ovf=%b expected 1/0", host_full, ovf);
        end
      end
      host_wr = 1'b1; host_addr = 8'h40 + 8'(i); host_data = 8'h10 + 8'(i);
      if (i < 8) begin
        exp_q.push_back({1'b0, 8'h40 + 8'(i)});
        exp_q.push_back({1'b1, 8'h10 + 8'(i)});
      end
      tick();
    end
    host_wr = 1'b0;
    n_cmp++;
    if ({ovf, host_full, host_level} !== {1'b1, 1'b1, 4'd8}) begin
      n_err++; $display("FAIL ovf_dropped: got ovf=%b full=%b level=%0d expected 1/1/8", ovf, host_full, host_level);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_err++; $display("FAIL ovf_clr: got %b expected 0", ovf);
    end
  endtask

  task automatic test_full_pop_push();
    int n;
    n = 0;
    while (dbg_state !== ST_WAIT && n < 30) begin tick(); n++; end
    n_cmp++;
    if (n >= 30) begin
      n_err++; $display("FAIL fpp_wait_timeout: got state=%0d expected 5", dbg_state);
    end
    busy_hold = 1'b0;
    host_wr = 1'b1; host_addr = 8'h7E; host_data = 8'h5A;
    exp_q.push_back({1'b0, 8'h7E});
    exp_q.push_back({1'b1, 8'h5A});
    tick();
    host_wr = 1'b0;
    n_cmp++;
    if ({host_level, ovf, host_full} !== {4'd8, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL fpp_level: got level=%0d ovf=%b full=%b expected 8/0/1", host_level, ovf, host_full);
    end
    n = 0;
    while (!host_empty && n < 400) begin tick(); n++; end
    n_cmp++;
    if (n >= 400) begin
      n_err++; $display("FAIL fpp_drain_timeout: got level=%0d expected 0", host_level);
    end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL fpp_strobe_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL fpp_strobe[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int n;
    busy_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      host_wr = 1'b1; host_addr = 8'h30 + 8'(i); host_data = 8'hA0 + 8'(i);
      tick();
    end
    host_wr = 1'b0;
    n = 0;
    while (dbg_state !== ST_WAIT && n < 30) begin tick(); n++; end
    n_cmp++;
    if (n >= 30 || host_level !== 4'd3) begin
      n_err++; $display("FAIL rmid_setup: got state=%0d level=%0d expected 5/3", dbg_state, host_level);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({write, host_level, host_empty, dbg_state} !== {1'b0, 4'd0, 1'b1, 3'd0}) begin
      n_err++; $display("FAIL rmid_async: got write=%b level=%0d empty=%b state=%0d expected 0/0/1/0", write, host_level, host_empty, dbg_state);
    end
    tick();
    rst = 1'b0;
    busy_hold = 1'b0;
    got_q.delete();
    repeat (20) tick();
    n_cmp++;
    if (got_q.size() != 0 || host_empty !== 1'b1) begin
      n_err++; $display("FAIL rmid_no_strobes: got strobes=%0d empty=%b expected 0/1", got_q.size(), host_empty);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_addr_cache();
    int n;
    host_wr = 1'b1; host_addr = 8'h08; host_data = 8'h78;
    tick();
    host_wr = 1'b1; host_addr = 8'h08; host_data = 8'h00;
    tick();
    host_wr = 1'b0;
    exp_q.push_back({1'b0, 8'h08});
    exp_q.push_back({1'b1, 8'h78});
`ifndef JT51_WRQ_ADDR_CACHE_EN
    exp_q.push_back({1'b0, 8'h08});
`endif
    exp_q.push_back({1'b1, 8'h00});
    n = 0;
    while (!host_empty && n < 100) begin tick(); n++; end
    n_cmp++;
    if (n >= 100) begin
      n_err++; $display("FAIL cache_drain_timeout: got level=%0d expected 0", host_level);
    end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL cache_strobe_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL cache_strobe[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; host_wr = 1'b0; host_addr = 8'h00; host_data = 8'h00; ovf_clr = 1'b0;
    repeat (2) tick();
    test_reset();
    test_single();
    test_overflow();
    test_full_pop_push();
    test_reset_mid();
    test_addr_cache();
    n_cmp++;
    if (pulse_viol != 0) begin
      n_err++; $display("FAIL strobe_pulse_width: got %0d back-to-back strobes expected 0", pulse_viol);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
